fma_write_buffer: RTL
=====================

Name: fma_write_buffer

Overview:
- Collects FMA result beats and packs them into data-cache lines.
- Presents the head line to memory with write_buffer_valid held high until memory consumes it.
- Consumption is detected by snooping the memory instruction stream for OP_LOADB (4'b1001); there is no explicit ack wire.
- Sits between the FMA block outputs and the memory write_buffer_read_in / write_buffer_valid_in inputs.

Parameters:
- FMA_COUNT, 2, number of FMAs delivering one result word each per beat.
- WORD_WIDTH, 16, bits per word.
- LINE_WIDTH, 96, bits per cache line; must be a multiple of FMA_COUNT*WORD_WIDTH.
- DEPTH, 2, number of completed lines held in the output FIFO.
- INSTRUCTION_WIDTH, 32, width of the snooped instruction.

Ports:
- clk_in  input  1  system clock, all logic on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- fma_result_in  input  FMA_COUNT*WORD_WIDTH  one beat of results; FMA i occupies bits [(FMA_COUNT-i)*WORD_WIDTH-1 -: WORD_WIDTH].
- result_valid_in  input  1  beat valid.
- result_ready_out  output  1  beat accepted when valid && ready.
- flush_in  input  1  single-cycle pulse; emit the partially filled line zero-padded.
- instr_in  input  [0:INSTRUCTION_WIDTH-1]  snooped memory instruction; opcode is in bits [0:3].
- instr_valid_in  input  1  snooped instruction valid.
- write_buffer_read_out  output  LINE_WIDTH  head line to memory.
- write_buffer_valid_out  output  1  head line present.
- lines_pending_out  output  $clog2(DEPTH+1)  FIFO occupancy.
- underflow_out  output  1  sticky; OP_LOADB seen while the FIFO was empty.

Behaviour:
- Reset (asynchronous, rst_in=0):
  - Outputs: result_ready_out=0, write_buffer_valid_out=0, write_buffer_read_out=0, lines_pending_out=0, underflow_out=0.
  - Internal state: beat_idx=0, assembly register=0, FIFO empty, flush_pending=0.
  - The first cycle after reset release has result_ready_out=1.
- BEATS = LINE_WIDTH/(FMA_COUNT*WORD_WIDTH), 3 at defaults.
- Packing:
  - Beat k, FMA i lands in word w = k*FMA_COUNT+i.
  - Word w occupies bits [LINE_WIDTH-1-w*WORD_WIDTH -: WORD_WIDTH], so word 0 is at the MSB (same word numbering as memory OP_LOADI).
- States, encoded by beat_idx:
  - FILL(0..BEATS-1): each accepted beat writes its slot; beat_idx increments.
  - On acceptance at beat_idx=BEATS-1, the assembled line is pushed into the FIFO in the same edge. beat_idx returns to 0 and the assembly register clears to 0.
- result_ready_out = (FIFO count < DEPTH). It is registered-state derived, with no combinational path from any input.
  - A beat that would not complete a line is still gated by this signal. This keeps the logic simple.
- Flush:
  - flush_in with beat_idx>0 pushes the assembly register (unfilled words = 0) and resets beat_idx.
  - flush_in with beat_idx=0 and no beat accepted in the same cycle is a no-op. No empty lines are ever produced.
  - flush_in in the same cycle as an accepted beat: that beat is included, then exactly one line is pushed. If that beat completes the line, only the one full line is pushed.
  - flush_in while the FIFO is full sets flush_pending. The flush executes on the first cycle with space, and no beats are accepted until it does.
- Output FIFO:
  - write_buffer_read_out always shows the head entry. write_buffer_valid_out = (count != 0).
  - Consume event: instr_valid_in && instr_in[0:3]==4'b1001.
  - A consume with count>0 pops the head; the next entry is visible on the following cycle.
  - A consume with count=0 is ignored and sets underflow_out, which stays set until reset.
- Simultaneous push and pop in the same cycle: count is unchanged and order is preserved.
- Memory latches the line one cycle before using it. The head entry therefore stays stable from the cycle it first appears until the edge on which it is popped.
- Other opcodes, and instr_valid_in=0, have no effect.
- Reset mid-line: the partial line and all queued lines are discarded.
- Pointers wrap modulo DEPTH.

Test Plan:
- Reset, then 3 beats {0x1111,0x2222}, {0x3333,0x4444}, {0x5555,0x6666} -> one cycle after the third beat: valid_out=1, read_out=0x111122223333444455556666, lines_pending_out=1.
- 2 beats {0xAAAA,0xBBBB}, {0xCCCC,0xDDDD}, then flush_in -> read_out=0xAAAABBBBCCCCDDDD00000000. A flush_in with beat_idx=0 -> lines_pending_out is unchanged.
- Fill 2 lines (6 beats), hold result_valid_in -> result_ready_out=0 and the 7th beat is not accepted. Snoop LOADB (0x9000_0000 with instr_valid_in) -> the next cycle shows line 2 at the head, lines_pending_out=1, ready=1.
- With 1 line queued, a completing beat and a LOADB in the same cycle -> lines_pending_out stays 1 and the new line is at the head next cycle.
- LOADB with the FIFO empty -> underflow_out=1 and stays 1. Opcode 0xA (OP_WRITEB) with 1 line queued -> no pop.
- Assert rst_in=0 asynchronously mid-line with 1 line queued -> valid_out=0 immediately. After release, the next 3 beats produce a line with no stale words.

Source files
------------

// File: rtl/fma_write_buffer_if.sv
// Bundles the FMA beat input, the flush pulse, the snooped instruction
// stream and the memory-facing head-line outputs of fma_write_buffer.
interface fma_write_buffer_if #(
  parameter int unsigned FMA_COUNT         = 2,
  parameter int unsigned WORD_WIDTH        = 16,
  parameter int unsigned LINE_WIDTH        = 96,
  parameter int unsigned DEPTH             = 2,
  parameter int unsigned INSTRUCTION_WIDTH = 32
);
  logic [FMA_COUNT*WORD_WIDTH-1:0] fma_result_in;
  logic                            result_valid_in;
  logic                            result_ready_out;
  logic                            flush_in;
  logic [0:INSTRUCTION_WIDTH-1]    instr_in;
  logic                            instr_valid_in;
  logic [LINE_WIDTH-1:0]           write_buffer_read_out;
  logic                            write_buffer_valid_out;
  logic [$clog2(DEPTH+1)-1:0]      lines_pending_out;
  logic                            underflow_out;

  // Producer / snooper side (FMA block, memory instruction stream).
  modport master (
    output fma_result_in, result_valid_in, flush_in, instr_in, instr_valid_in,
    input  result_ready_out, write_buffer_read_out, write_buffer_valid_out,
           lines_pending_out, underflow_out
  );

  // Write buffer side.
  modport slave (
    input  fma_result_in, result_valid_in, flush_in, instr_in, instr_valid_in,
    output result_ready_out, write_buffer_read_out, write_buffer_valid_out,
           lines_pending_out, underflow_out
  );
endinterface

// File: rtl/fma_write_buffer.sv
// Packs FMA result beats into cache lines, queues completed lines in a small
// FIFO and presents the head line to memory. A line is consumed when an
// OP_LOADB instruction is seen on the snooped instruction stream.
module fma_write_buffer #(
  parameter int unsigned FMA_COUNT         = 2,
  parameter int unsigned WORD_WIDTH        = 16,
  parameter int unsigned LINE_WIDTH        = 96,
  parameter int unsigned DEPTH             = 2,
  parameter int unsigned INSTRUCTION_WIDTH = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  fma_write_buffer_if.slave bus
);

  localparam int unsigned BEAT_W = FMA_COUNT * WORD_WIDTH;
  localparam int unsigned BEATS  = LINE_WIDTH / BEAT_W;
  localparam int unsigned IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [3:0]       OP_LOADB  = 4'b1001;

  logic [IDX_W-1:0]      beat_idx, beat_next;
  logic [LINE_WIDTH-1:0] asm_reg, asm_next, merged, push_data;
  logic                  flush_pending, flush_pending_next;
  logic                  run;

  logic [LINE_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  underflow;

  logic space, accept, flush_do, push, pop, consume;
  logic unused_instr_bits;

  // Only the opcode field of the snooped instruction matters here.
  always_comb unused_instr_bits = ^bus.instr_in[4:INSTRUCTION_WIDTH-1];

  // Overlay the incoming beat onto its slot; beat 0 lands at the MSB end.
  always_comb begin
    merged = asm_reg;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (beat_idx == IDX_W'(k)) begin
        merged[LINE_WIDTH-1-k*BEAT_W -: BEAT_W] = bus.fma_result_in;
      end
    end
  end

  // Next-state: beat acceptance, line push (complete or flush) and FIFO pop.
  // A deferred flush waits in flush_pending and fires as soon as the FIFO has
  // room; a beat accepted in that same cycle is folded into the flushed line.
  always_comb begin
    space    = count < CNT_W'(DEPTH);
    accept   = bus.result_valid_in && run && space;
    flush_do = (bus.flush_in || flush_pending) && space;
    push     = (accept && (beat_idx == LAST_BEAT)) ||
               (flush_do && (accept || (beat_idx != '0)));
    push_data = accept ? merged : asm_reg;

    consume = bus.instr_valid_in && (bus.instr_in[0:3] == OP_LOADB);
    pop     = consume && (count != '0);

    flush_pending_next = flush_pending;
    if (flush_do) begin
      flush_pending_next = 1'b0;
    end else if (bus.flush_in && !space) begin
      flush_pending_next = 1'b1;
    end

    beat_next = beat_idx;
    asm_next  = asm_reg;
    if (push) begin
      beat_next = '0;
      asm_next  = '0;
    end else if (accept) begin
      beat_next = beat_idx + IDX_W'(1);
      asm_next  = merged;
    end
  end

  // Line-assembly state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      beat_idx      <= '0;
      asm_reg       <= '0;
      flush_pending <= 1'b0;
      run           <= 1'b0;
    end else begin
      beat_idx      <= beat_next;
      asm_reg       <= asm_next;
      flush_pending <= flush_pending_next;
      run           <= 1'b1;
    end
  end

  // Output FIFO of completed lines plus the sticky underflow flag.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (consume && (count == '0)) begin
        underflow <= 1'b1;
      end
    end
  end

  // Outputs are derived from registered state only.
  always_comb begin
    bus.result_ready_out       = run && space;
    bus.write_buffer_read_out  = mem[rd_ptr];
    bus.write_buffer_valid_out = count != '0;
    bus.lines_pending_out      = count;
    bus.underflow_out          = underflow;
  end

endmodule
